// File: rtl/mux_nibble_serializer.sv
// mux_nibble_serializer
// Drives a latched nibble onto the data inputs of a downstream 4:1 mux, walks
// the select lines through 0..3, waits a programmable settle time on each
// select value and samples the mux output back. The recovered nibble is
// compared against the driven one and reported with a one-cycle done pulse.
// Every output comes straight from a flop; nothing reaches an output
// combinationally from an input.
module mux_nibble_serializer #(
    parameter int unsigned SETTLE = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] din_i,
    input  logic       mux_out_i,
    output logic [3:0] mux_data_o,
    output logic [1:0] mux_sel_o,
    output logic       busy_o,
    output logic       bit_valid_o,
    output logic [3:0] dout_o,
    output logic       done_o,
    output logic       err_o
);

    // Settle time is clamped to its legal range so an out-of-range
    // parameter can never underflow the counter or overflow its width.
    localparam int unsigned SETTLE_EFF = (SETTLE < 32'd1)  ? 32'd1  :
                                         (SETTLE > 32'd15) ? 32'd15 : SETTLE;
    localparam logic [3:0]  CNT_RELOAD = 4'(SETTLE_EFF - 32'd1);

    // Sequencer states. All four codes are used; the default branch still
    // returns anything unexpected to IDLE.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] SEL_FIRST = 2'd0;
    localparam logic [1:0] SEL_LAST  = 2'd3;

    logic [1:0] state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic [3:0] mux_data_q,  mux_data_d;
    logic [1:0] mux_sel_q,   mux_sel_d;
    logic [3:0] dout_q,      dout_d;
    logic       busy_q,      busy_d;
    logic       bit_valid_q, bit_valid_d;
    logic       done_q,      done_d;
    logic       err_q,       err_d;

    // Replace one bit of a nibble, selected by a 2-bit position.
    function automatic logic [3:0] insert_bit(
        input logic [3:0] word,
        input logic [1:0] pos,
        input logic       value
    );
        logic [3:0] result;
        result      = word;
        result[pos] = value;
        return result;
    endfunction

    // Loopback check: any difference between what was driven and what came back.
    function automatic logic loopback_mismatch(
        input logic [3:0] sent,
        input logic [3:0] received
    );
        return (sent != received);
    endfunction

    // Next-state and datapath decisions for one serialization transaction.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mux_data_d  = mux_data_q;
        mux_sel_d   = mux_sel_q;
        dout_d      = dout_q;
        err_d       = err_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // Latch the nibble and begin with select 0; the previous
                    // result and error are discarded here.
                    mux_data_d = din_i;
                    mux_sel_d  = SEL_FIRST;
                    dout_d     = 4'd0;
                    err_d      = 1'b0;
                    cnt_d      = CNT_RELOAD;
                    state_d    = ST_SETTLE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                // Counter runs SETTLE-1 down to 0, so this state lasts
                // exactly SETTLE cycles.
                if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end

            ST_SAMPLE: begin
                dout_d      = insert_bit(dout_q, mux_sel_q, mux_out_i);
                bit_valid_d = 1'b1;
                if (mux_sel_q == SEL_LAST) begin
                    // Error is judged on the fully assembled nibble,
                    // including the bit captured on this very edge.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = loopback_mismatch(mux_data_q, dout_d);
                end else begin
                    mux_sel_d = mux_sel_q + 2'd1;
                    cnt_d     = CNT_RELOAD;
                    state_d   = ST_SETTLE;
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy is registered from the next state so it lines up with it.
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and settle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs towards the mux and towards the consumer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mux_data_q  <= 4'd0;
            mux_sel_q   <= 2'd0;
            dout_q      <= 4'd0;
            busy_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mux_data_q  <= mux_data_d;
            mux_sel_q   <= mux_sel_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mux_data_o  = mux_data_q;
    assign mux_sel_o   = mux_sel_q;
    assign busy_o      = busy_q;
    assign bit_valid_o = bit_valid_q;
    assign dout_o      = dout_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mux_nibble_serializer.sv
// Testbench for mux_nibble_serializer: two instances (SETTLE=3 at period 10,
// SETTLE=1 at period 15), each looped back through a delayed 4:1 mux model.
// A timeline model predicts every output from the number of edges elapsed
// since the accepted start.
module tb_mux_nibble_serializer;

    logic clk0 = 1'b0;
    logic clk1 = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    logic       start_s [2] = '{1'b0, 1'b0};
    logic [3:0] din_s   [2] = '{4'd0, 4'd0};
    logic       fault_s [2] = '{1'b0, 1'b0};
    logic       mux_out0;
    logic       mux_out1;

    logic [3:0] mux_data_s [2];
    logic [1:0] mux_sel_s  [2];
    logic       busy_s     [2];
    logic       bv_s       [2];
    logic [3:0] dout_s     [2];
    logic       done_s     [2];
    logic       err_s      [2];

    int total = 0;
    int bad   = 0;
    int cyc      [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int bv_cnt   [2] = '{0, 0};
    bit fin      [2] = '{1'b0, 1'b0};

    // Timeline model: m_t = edges since accepted start, -1 before any start.
    int         m_per  [2] = '{4, 2};
    int         m_t    [2] = '{-1, -1};
    logic [3:0] m_data [2] = '{4'd0, 4'd0};
    logic [3:0] m_dout [2] = '{4'd0, 4'd0};
    logic [1:0] m_sel  [2] = '{2'd0, 2'd0};
    logic       m_err  [2] = '{1'b0, 1'b0};

    always #5 clk0 = ~clk0;
    always begin
        #7 clk1 = 1'b1;
        #8 clk1 = 1'b0;
    end

    // Gate-level 4:1 mux stand-in with an 11-unit path (below the 12 worst case).
    assign #11 mux_out0 = fault_s[0] ? 1'b0 : mux_data_s[0][mux_sel_s[0]];
    assign #11 mux_out1 = fault_s[1] ? 1'b0 : mux_data_s[1][mux_sel_s[1]];

    mux_nibble_serializer #(.SETTLE(3)) u_dut0 (
        .clk_i(clk0), .rst_i(rst0), .start_i(start_s[0]), .din_i(din_s[0]),
        .mux_out_i(mux_out0), .mux_data_o(mux_data_s[0]), .mux_sel_o(mux_sel_s[0]),
        .busy_o(busy_s[0]), .bit_valid_o(bv_s[0]), .dout_o(dout_s[0]),
        .done_o(done_s[0]), .err_o(err_s[0])
    );

    mux_nibble_serializer #(.SETTLE(1)) u_dut1 (
        .clk_i(clk1), .rst_i(rst1), .start_i(start_s[1]), .din_i(din_s[1]),
        .mux_out_i(mux_out1), .mux_data_o(mux_data_s[1]), .mux_sel_o(mux_sel_s[1]),
        .busy_o(busy_s[1]), .bit_valid_o(bv_s[1]), .dout_o(dout_s[1]),
        .done_o(done_s[1]), .err_o(err_s[1])
    );

    task automatic check(input string name, input int u, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", name, u, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int u);
        if (u == 0) @(negedge clk0);
        else        @(negedge clk1);
    endtask

    task automatic model_reset(input int u);
        m_t[u]    = -1;
        m_data[u] = 4'd0;
        m_dout[u] = 4'd0;
        m_sel[u]  = 2'd0;
        m_err[u]  = 1'b0;
    endtask

    task automatic model_edge(input int u);
        int p;
        int j;
        p = m_per[u];
        if ((m_t[u] < 0 || m_t[u] == 4 * p + 1) && start_s[u]) begin
            m_t[u]    = 0;
            m_data[u] = din_s[u];
            m_dout[u] = 4'd0;
            m_err[u]  = 1'b0;
            m_sel[u]  = 2'd0;
        end else if (m_t[u] >= 0 && m_t[u] < 4 * p + 1) begin
            m_t[u] = m_t[u] + 1;
            if (m_t[u] % p == 0 && m_t[u] <= 4 * p) begin
                j = m_t[u] / p;
                m_dout[u][j-1] = fault_s[u] ? 1'b0 : m_data[u][j-1];
            end
            if (m_t[u] == 4 * p) m_err[u] = (m_dout[u] != m_data[u]);
            m_sel[u] = 2'((m_t[u] / p > 3) ? 3 : m_t[u] / p);
        end
    endtask

    task automatic compare(input int u);
        int p;
        int t;
        logic e_busy;
        logic e_bv;
        logic e_done;
        p = m_per[u];
        t = m_t[u];
        e_busy = (t >= 0) && (t <= 4 * p);
        e_bv   = (t >= 1) && (t <= 4 * p) && (t % p == 0);
        e_done = (t == 4 * p);
        check("mux_data",  u, 8'(mux_data_s[u]), 8'(m_data[u]));
        check("mux_sel",   u, 8'(mux_sel_s[u]),  8'(m_sel[u]));
        check("busy",      u, 8'(busy_s[u]),     8'(e_busy));
        check("bit_valid", u, 8'(bv_s[u]),       8'(e_bv));
        check("dout",      u, 8'(dout_s[u]),     8'(m_dout[u]));
        check("done",      u, 8'(done_s[u]),     8'(e_done));
        check("err",       u, 8'(err_s[u]),      8'(m_err[u]));
        if (done_s[u] === 1'b1) done_cnt[u]++;
        if (bv_s[u] === 1'b1)   bv_cnt[u]++;
    endtask

    // Model advance on each edge, reset asynchronously like the DUT.
    always @(posedge clk0 or posedge rst0) begin
        if (rst0) model_reset(0);
        else      model_edge(0);
    end
    always @(posedge clk1 or posedge rst1) begin
        if (rst1) model_reset(1);
        else      model_edge(1);
    end

    // Edge counters and per-cycle comparison away from the active edge.
    always @(posedge clk0) cyc[0] <= cyc[0] + 1;
    always @(posedge clk1) cyc[1] <= cyc[1] + 1;
    always @(negedge clk0) compare(0);
    always @(negedge clk1) compare(1);

    // One accepted transaction from IDLE, with literal expectations at done.
    task automatic run_txn(input int u, input logic [3:0] d, input logic f,
                           input bit noise, input logic [7:0] lat);
        int k;
        int bv0;
        logic [3:0] exp_dout;
        exp_dout   = f ? 4'd0 : d;
        fault_s[u] = f;
        din_s[u]   = d;
        start_s[u] = 1'b1;
        k   = cyc[u] + 1;
        bv0 = bv_cnt[u];
        wait_neg(u);
        start_s[u] = 1'b0;
        check("accept_busy", u, 8'(busy_s[u]), 8'd1);
        check("err_clear",   u, 8'(err_s[u]),  8'd0);
        for (int i = 0; i < 100; i++) begin
            if (done_s[u] === 1'b1) break;
            if (noise) begin
                start_s[u] = 1'($urandom_range(0, 1));
                din_s[u]   = 4'($urandom);
            end
            wait_neg(u);
        end
        start_s[u] = 1'b0;
        check("done_seen", u, 8'(done_s[u]),   8'd1);
        check("done_lat",  u, 8'(cyc[u] - k),  lat);
        check("done_dout", u, 8'(dout_s[u]),   8'(exp_dout));
        check("done_err",  u, 8'(err_s[u]),    8'(exp_dout != d));
        wait_neg(u);
        check("bv_count",  u, 8'(bv_cnt[u] - bv0), 8'd4);
        check("idle_busy", u, 8'(busy_s[u]),   8'd0);
    endtask

    // Directed and random stimulus for the SETTLE=3 instance.
    initial begin : stim0
        int dn;
        int idx;
        int last;
        logic [3:0] nib [4];
        repeat (3) @(negedge clk0);
        rst0 = 1'b0;
        @(negedge clk0);
        check("rst_busy", 0, 8'(busy_s[0]),     8'd0);
        check("rst_sel",  0, 8'(mux_sel_s[0]),  8'd0);
        check("rst_data", 0, 8'(mux_data_s[0]), 8'd0);
        check("rst_err",  0, 8'(err_s[0]),      8'd0);

        run_txn(0, 4'hE, 1'b0, 1'b0, 8'd16);

        // Back-to-back with start held high; din scrambled while busy.
        nib  = '{4'hA, 4'hC, 4'hB, 4'h0};
        idx  = 0;
        dn   = 0;
        last = 0;
        for (int i = 0; i < 200 && dn < 4; i++) begin
            if (done_s[0] === 1'b1) begin
                check("b2b_dout", 0, 8'(dout_s[0]), 8'(nib[dn]));
                check("b2b_err",  0, 8'(err_s[0]),  8'd0);
                if (dn > 0) check("b2b_period", 0, 8'(cyc[0] - last), 8'd18);
                last = cyc[0];
                dn++;
            end
            if (busy_s[0] === 1'b0) begin
                if (idx < 4) begin
                    din_s[0]   = nib[idx];
                    start_s[0] = 1'b1;
                    idx++;
                end else begin
                    start_s[0] = 1'b0;
                end
            end else begin
                din_s[0] = 4'($urandom);
            end
            wait_neg(0);
        end
        start_s[0] = 1'b0;
        check("b2b_count", 0, 8'(dn), 8'd4);
        wait_neg(0);

        // Stuck-at-0 mux output.
        run_txn(0, 4'hA, 1'b1, 1'b0, 8'd16);
        repeat (3) wait_neg(0);
        check("err_hold", 0, 8'(err_s[0]), 8'd1);
        run_txn(0, 4'h6, 1'b0, 1'b0, 8'd16);

        // Reset while mux_sel==2.
        din_s[0] = 4'h7; start_s[0] = 1'b1;
        wait_neg(0);
        start_s[0] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mux_sel_s[0] == 2'd2) break;
            wait_neg(0);
        end
        check("mid_sel", 0, 8'(mux_sel_s[0]), 8'd2);
        dn = done_cnt[0];
        #2 rst0 = 1'b1;
        #1;
        check("async_data", 0, 8'(mux_data_s[0]), 8'd0);
        check("async_sel",  0, 8'(mux_sel_s[0]),  8'd0);
        check("async_busy", 0, 8'(busy_s[0]),     8'd0);
        check("async_dout", 0, 8'(dout_s[0]),     8'd0);
        check("async_bv",   0, 8'(bv_s[0]),       8'd0);
        check("async_err",  0, 8'(err_s[0]),      8'd0);
        repeat (2) wait_neg(0);
        rst0 = 1'b0;
        run_txn(0, 4'hB, 1'b0, 1'b0, 8'd16);
        check("rst_done_cnt", 0, 8'(done_cnt[0] - dn), 8'd1);

        // start during SETTLE and DONE is ignored.
        dn = done_cnt[0];
        din_s[0] = 4'h3; start_s[0] = 1'b1;
        wait_neg(0);
        start_s[0] = 1'b0;
        wait_neg(0);
        din_s[0] = 4'h9; start_s[0] = 1'b1;
        wait_neg(0);
        start_s[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_s[0] === 1'b1) break;
            wait_neg(0);
        end
        check("ign_dout", 0, 8'(dout_s[0]), 8'h3);
        start_s[0] = 1'b1;
        wait_neg(0);
        start_s[0] = 1'b0;
        repeat (30) wait_neg(0);
        check("ign_done_cnt", 0, 8'(done_cnt[0] - dn), 8'd1);
        check("ign_busy",     0, 8'(busy_s[0]),        8'd0);

        // Random transactions with start/din noise while busy.
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) wait_neg(0);
            run_txn(0, 4'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1, 8'd16);
        end
        fin[0] = 1'b1;
    end

    // SETTLE=1 instance at period 15.
    initial begin : stim1
        repeat (3) @(negedge clk1);
        rst1 = 1'b0;
        @(negedge clk1);
        check("rst_busy", 1, 8'(busy_s[1]), 8'd0);
        run_txn(1, 4'h5, 1'b0, 1'b0, 8'd8);
        for (int n = 0; n < 15; n++) begin
            repeat ($urandom_range(0, 2)) wait_neg(1);
            run_txn(1, 4'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1, 8'd8);
        end
        fin[1] = 1'b1;
    end

    initial begin : finisher
        wait (fin[0] && fin[1]);
        repeat (2) @(negedge clk0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        bad++;
        $display("FAIL watchdog got=timeout want=completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
